// File: rtl/sqdiff_if.sv
// Sample/result bundle for the framed sum-of-squared-differences accumulator.
interface sqdiff_if #(
    parameter int unsigned SIZEIN    = 8,
    parameter int unsigned SIZEOUT   = 20,
    parameter int unsigned FRAME_LEN = 16
) ();
    localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

    logic                       ce;
    logic                       in_valid;
    logic                       sload;
    logic signed [SIZEIN-1:0]   a;
    logic signed [SIZEIN-1:0]   b;
    logic signed [SIZEOUT-1:0]  accum_out;
    logic                       out_valid;
    logic                       overflow;
    logic [CNT_W-1:0]           sample_cnt;

    modport master (
        output ce, in_valid, sload, a, b,
        input  accum_out, out_valid, overflow, sample_cnt
    );

    modport slave (
        input  ce, in_valid, sload, a, b,
        output accum_out, out_valid, overflow, sample_cnt
    );
endinterface

// File: rtl/sqdiff_frame_macc.sv
// Framed, pipelined (a-b)^2 accumulator with per-frame total strobe.
// Optional SQDIFF_SAT_EN: accumulator saturates instead of wrapping.
module sqdiff_frame_macc #(
    parameter int unsigned SIZEIN    = 8,
    parameter int unsigned SIZEOUT   = 20,
    parameter int unsigned FRAME_LEN = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    sqdiff_if.slave     bus
);
    localparam int unsigned DW    = SIZEIN + 1;
    localparam int unsigned SQW   = 2 * SIZEIN + 2;
    localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic signed [SIZEOUT-1:0] SAT_MAX = {1'b0, {(SIZEOUT-1){1'b1}}};

    logic signed [SIZEIN-1:0]  a1_q, b1_q;
    logic                      v1_q, s1_q, v2_q, s2_q, v3_q, s3_q;
    logic signed [DW-1:0]      diff2_q;
    logic signed [SQW-1:0]     sq3_q;
    logic signed [SIZEOUT-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      ovf_q, ovf_d;
    logic                      oval_q, oval_d;

    logic signed [SIZEOUT-1:0] sq_ext;
    logic signed [SIZEOUT-1:0] sum;
    logic                      first;
    logic                      wrap;

    // Stage-4 next state; cnt==0 only right after reset, cnt==FRAME_LEN after a completed frame
    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        oval_d = 1'b0;
        sq_ext = SIZEOUT'(sq3_q);
        sum    = acc_q + sq_ext;
        first  = s3_q || (cnt_q == '0) || (cnt_q == CNT_W'(FRAME_LEN));
        wrap   = !acc_q[SIZEOUT-1] && sum[SIZEOUT-1];
        if (bus.ce && v3_q) begin
            if (first) begin
                acc_d = sq_ext;
                cnt_d = CNT_W'(1);
                ovf_d = 1'b0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
                if (wrap) begin
                    ovf_d = 1'b1;
`ifdef SQDIFF_SAT_EN
                    acc_d = SAT_MAX;
`else
                    acc_d = sum;
`endif
                end
            end
            oval_d = (cnt_d == CNT_W'(FRAME_LEN));
        end
    end

    // Pipeline and accumulator registers; out_valid is a single-edge strobe independent of ce
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1_q    <= '0;
            b1_q    <= '0;
            v1_q    <= 1'b0;
            s1_q    <= 1'b0;
            v2_q    <= 1'b0;
            s2_q    <= 1'b0;
            diff2_q <= '0;
            v3_q    <= 1'b0;
            s3_q    <= 1'b0;
            sq3_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            oval_q  <= 1'b0;
        end else begin
            oval_q <= oval_d;
            if (bus.ce) begin
                a1_q    <= bus.a;
                b1_q    <= bus.b;
                v1_q    <= bus.in_valid;
                s1_q    <= bus.in_valid & bus.sload;
                diff2_q <= DW'(a1_q) - DW'(b1_q);
                v2_q    <= v1_q;
                s2_q    <= s1_q;
                sq3_q   <= SQW'(diff2_q) * SQW'(diff2_q);
                v3_q    <= v2_q;
                s3_q    <= s2_q;
                acc_q   <= acc_d;
                cnt_q   <= cnt_d;
                ovf_q   <= ovf_d;
            end
        end
    end

    assign bus.accum_out  = acc_q;
    assign bus.sample_cnt = cnt_q;
    assign bus.overflow   = ovf_q;
    assign bus.out_valid  = oval_q;
endmodule

// File: tb/tb_sqdiff_frame_macc.sv
// Scoreboard bench: FRAME_LEN=4 and default-parameter instances driven with identical stimulus.
module tb_sqdiff_frame_macc;
    localparam longint MAXV = 524287;

    typedef struct {
        longint acc;
        int     cnt;
        bit     ovf;
        bit     ov;
    } exp_t;

    logic clk;
    logic rst_n;
    logic ce, in_valid, sload;
    logic signed [7:0] a, b;

    int checks   = 0;
    int failures = 0;

    exp_t q0[$];
    exp_t q1[$];

    longint m_sum[2];
    int     m_cnt[2];
    bit     m_ovf[2];
    bit     m_fresh[2];
    int     fl[2] = '{4, 16};

    logic [2:0] tag;
    logic       pop_now;
    int         ov4_pulses;

    sqdiff_if #(.FRAME_LEN(4)) bus4 ();
    sqdiff_if                  bus16 ();

    assign bus4.ce        = ce;
    assign bus4.in_valid  = in_valid;
    assign bus4.sload     = sload;
    assign bus4.a         = a;
    assign bus4.b         = b;
    assign bus16.ce       = ce;
    assign bus16.in_valid = in_valid;
    assign bus16.sload    = sload;
    assign bus16.a        = a;
    assign bus16.b        = b;

    sqdiff_frame_macc #(.FRAME_LEN(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    sqdiff_frame_macc                  dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_sum[d]   = 0;
            m_cnt[d]   = 0;
            m_ovf[d]   = 1'b0;
            m_fresh[d] = 1'b1;
        end
        q0.delete();
        q1.delete();
    endtask

    // Reference: track the true sum, then derive saturated or wrapped register value
    task automatic model_push(input bit sl, input int av, input int bv);
        longint sq;
        exp_t   e;
        logic signed [19:0] w;
        logic [63:0] raw;
        sq = longint'(av - bv) * longint'(av - bv);
        for (int d = 0; d < 2; d++) begin
            if (sl || m_fresh[d]) begin
                m_sum[d]   = sq;
                m_cnt[d]   = 1;
                m_ovf[d]   = 1'b0;
                m_fresh[d] = 1'b0;
            end else begin
                m_sum[d] += sq;
                m_cnt[d]++;
            end
            if (m_sum[d] > MAXV) m_ovf[d] = 1'b1;
            raw = m_sum[d];
            w   = raw[19:0];
`ifdef SQDIFF_SAT_EN
            e.acc = m_ovf[d] ? MAXV : m_sum[d];
`else
            e.acc = longint'(w);
`endif
            e.cnt = m_cnt[d];
            e.ovf = m_ovf[d];
            e.ov  = (m_cnt[d] == fl[d]);
            if (e.ov) m_fresh[d] = 1'b1;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic drive(input bit c, input bit v, input bit sl, input int av, input int bv);
        @(negedge clk);
        ce       = c;
        in_valid = v;
        sload    = sl;
        a        = 8'(av);
        b        = 8'(bv);
        if (c && v) model_push(sl, av, bv);
    endtask

    task automatic drain();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 0, 0);
    endtask

    // Tags a ce-qualified sample through the three stages ahead of the accumulator
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag     <= '0;
            pop_now <= 1'b0;
        end else begin
            pop_now <= ce && tag[2];
            if (ce) tag <= {tag[1:0], in_valid};
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus4.out_valid === 1'b1) ov4_pulses++;
            if (pop_now) begin
                exp_t e0, e1;
                if (q0.size() == 0 || q1.size() == 0) begin
                    chk("queue_nonempty", 64'(q0.size() * q1.size()), 64'sd1);
                end else begin
                    e0 = q0.pop_front();
                    e1 = q1.pop_front();
                    chk("f4_acc",  bus4.accum_out,  e0.acc);
                    chk("f4_cnt",  bus4.sample_cnt, 64'(e0.cnt));
                    chk("f4_ovf",  bus4.overflow,   64'(e0.ovf));
                    chk("f4_oval", bus4.out_valid,  64'(e0.ov));
                    chk("f16_acc", bus16.accum_out, e1.acc);
                    chk("f16_cnt", bus16.sample_cnt, 64'(e1.cnt));
                    chk("f16_ovf", bus16.overflow,  64'(e1.ovf));
                    chk("f16_oval", bus16.out_valid, 64'(e1.ov));
                end
            end else begin
                chk("f4_oval_idle",  bus4.out_valid,  64'sd0);
                chk("f16_oval_idle", bus16.out_valid, 64'sd0);
            end
        end
    end

    task automatic check_all_zero(input string name);
        chk({name, "_f4_acc"},   bus4.accum_out,   64'sd0);
        chk({name, "_f4_cnt"},   bus4.sample_cnt,  64'sd0);
        chk({name, "_f4_ovf"},   bus4.overflow,    64'sd0);
        chk({name, "_f4_oval"},  bus4.out_valid,   64'sd0);
        chk({name, "_f16_acc"},  bus16.accum_out,  64'sd0);
        chk({name, "_f16_cnt"},  bus16.sample_cnt, 64'sd0);
        chk({name, "_f16_ovf"},  bus16.overflow,   64'sd0);
        chk({name, "_f16_oval"}, bus16.out_valid,  64'sd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        ce         = 1'b0;
        in_valid   = 1'b0;
        sload      = 1'b0;
        a          = '0;
        b          = '0;
        ov4_pulses = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Frame of four 9s, then one more sample starting the next frame
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 5, 2);
        drain();
        chk("t1_f4_acc", bus4.accum_out, 64'sd9);
        chk("t1_f4_cnt", bus4.sample_cnt, 64'sd1);
        chk("t1_f16_acc", bus16.accum_out, 64'sd45);

        // Nine maximal squares: overflow on the ninth
        drive(1'b1, 1'b1, 1'b1, 127, -128);
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 127, -128);
        drain();
`ifdef SQDIFF_SAT_EN
        chk("t2_f16_acc", bus16.accum_out, 64'sd524287);
`else
        chk("t2_f16_acc", bus16.accum_out, -64'sd463351);
`endif
        chk("t2_f16_ovf", bus16.overflow, 64'sd1);
        chk("t2_f16_cnt", bus16.sample_cnt, 64'sd9);

        // Mid-frame sload discards 1+4+9
        drive(1'b1, 1'b1, 1'b1, 1, 0);
        drive(1'b1, 1'b1, 1'b0, 2, 0);
        drive(1'b1, 1'b1, 1'b0, 3, 0);
        drive(1'b1, 1'b1, 1'b1, 4, 0);
        drain();
        chk("t3_f4_acc", bus4.accum_out, 64'sd16);
        chk("t3_f4_cnt", bus4.sample_cnt, 64'sd1);
        chk("t3_f4_ovf", bus4.overflow, 64'sd0);
        chk("t3_f16_ovf", bus16.overflow, 64'sd0);

        // Bubbles plus a three-cycle ce stall inside one frame
        ov4_pulses = 0;
        drive(1'b1, 1'b1, 1'b1, 5, 2);
        drive(1'b1, 1'b0, 1'b0, 0, 0);
        drive(1'b1, 1'b1, 1'b0, 5, 2);
        drive(1'b0, 1'b1, 1'b0, 5, 2);
        drive(1'b0, 1'b1, 1'b0, 5, 2);
        drive(1'b0, 1'b1, 1'b0, 5, 2);
        drive(1'b1, 1'b0, 1'b0, 0, 0);
        drive(1'b1, 1'b1, 1'b0, 5, 2);
        drive(1'b1, 1'b0, 1'b1, 9, 0);
        drive(1'b1, 1'b1, 1'b0, 5, 2);
        drain();
        chk("t4_f4_acc", bus4.accum_out, 64'sd36);
        chk("t4_f4_pulses", 64'(ov4_pulses), 64'sd1);

        // Asynchronous reset between edges mid-frame
        drive(1'b1, 1'b1, 1'b1, 7, 1);
        drive(1'b1, 1'b1, 1'b0, 7, 1);
        drain();
        drive(1'b1, 1'b1, 1'b0, 7, 1);
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        ce       = 1'b0;
        in_valid = 1'b0;
        sload    = 1'b0;
        model_reset();
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 3, 1);
        drain();
        chk("t5_f4_cnt", bus4.sample_cnt, 64'sd1);
        chk("t5_f4_acc", bus4.accum_out, 64'sd4);
        chk("t5_f16_cnt", bus16.sample_cnt, 64'sd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sqdiff_frame_macc.md
# sqdiff_frame_macc

Framed, pipelined sum-of-squared-differences accumulator. It is the parametrised successor to the single-loop square-diff MACC. Per accepted sample it computes (a-b)² and accumulates over a frame of FRAME_LEN samples, then presents the frame total with a one-cycle `out_valid` strobe. It sits in the DSP datapath after sample capture and maps to one DSP slice plus frame-control logic.

## Interface
Parameters:
- SIZEIN, 8, signed input width
- SIZEOUT, 20, accumulator/output width; must be ≥ 2*SIZEIN+1
- FRAME_LEN, 16, samples per frame; must be ≥ 2

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- ce  in  1  pipeline clock enable
- in_valid  in  1  sample qualifier
- sload  in  1  start a new frame with this sample; honoured only with in_valid
- a  in  SIZEIN  signed minuend
- b  in  SIZEIN  signed subtrahend
- accum_out  out  SIZEOUT  signed running/frame sum
- out_valid  out  1  frame-complete strobe
- overflow  out  1  sticky per-frame overflow flag
- sample_cnt  out  clog2(FRAME_LEN+1)  samples accumulated in current frame

## Operation
- Every stage register (stages 1–4) and all outputs update only on edges with ce=1. The one exception is `out_valid`, covered below.
- Stage 1 registers a, b, in_valid and sload. Stage 2 computes diff = a-b, SIZEIN+1 bits signed. Stage 3 computes sq = diff*diff, 2*SIZEIN+2 bits signed. Stage 4 is the accumulator.
- Invalid samples travel as bubbles. They do not change the accumulator, sample_cnt or overflow.
- A stage-4 valid sample is "first" when one of these holds:
  - its sload tag is set;
  - the previous frame completed;
  - it is the first sample after reset.
- On a first sample: accumulator := sq, sample_cnt := 1, overflow := 0.
- On any other valid sample: accumulator := accumulator + sq, and sample_cnt increments.
- When sample_cnt reaches FRAME_LEN:
  - out_valid is registered high;
  - the next valid sample is first.
- An sload tag on a sample mid-frame discards the partial frame. No out_valid is generated for the discarded frame.
- Overflow occurs when the true sum exceeds 2^(SIZEOUT-1)-1. Because sq ≥ 0, no negative overflow exists. On overflow, overflow is set and held until the next first sample.
- accum_out is the accumulator register directly. Between frames it holds the completed total.
- out_valid is high for exactly one clk cycle. It clears on the next edge whatever ce is.

## Timing
- Reset (rst_n=0, async): all pipeline registers, accum_out, sample_cnt, out_valid and overflow are 0. The valid tags are cleared.
- Latency is counted in ce=1 edges. A sample captured at edge E is reflected in accum_out, sample_cnt and overflow after edge E+3.
- out_valid rises after edge E+3 for the frame's last sample.
- Throughput is one sample per ce=1 cycle. ce=0 freezes the pipeline with no loss of data.
- sload with in_valid=0 is ignored.
- sload on the sample that would also be the (FRAME_LEN+1)-th: it is a first sample either way, so there is no conflict.
- Reset asserted mid-frame clears the frame immediately. The partial frame is never reported.

## Configuration
- SQDIFF_SAT_EN defined: the accumulator saturates.
  - On overflow, accumulator := 2^(SIZEOUT-1)-1 and stays clamped until the next first sample.
  - overflow is set.
- SQDIFF_SAT_EN undefined: the accumulator wraps modulo 2^SIZEOUT, two's complement. overflow is still set on the first wrap.

## Test plan
- FRAME_LEN=4, a=5, b=2 each cycle, in_valid=1 → accum_out 9, 18, 27, 36. out_valid pulses once with 36 and sample_cnt=4. The next sample gives accum_out=9.
- Default params, 9 samples of a=127, b=-128 (sq=65025):
  - with SQDIFF_SAT_EN → accum_out=524287 and overflow=1 from the 9th sample on;
  - without SQDIFF_SAT_EN → accum_out=-463351 and overflow=1.
- FRAME_LEN=4, samples sq=1,4,9, then a 4th sample with sload=1 and sq=16 → no out_valid. accum_out=16, sample_cnt=1, overflow cleared.
- FRAME_LEN=4, alternate in_valid 1/0 and hold ce=0 for 3 cycles mid-frame → same total (36 for a=5, b=2) and one out_valid. The stall adds exactly 3 cycles of latency.
- rst_n pulled low asynchronously between edges mid-frame → all outputs read 0 before the next clk edge. After release, the first sample starts a fresh frame with sample_cnt=1.
